// File: rtl/uart_aes_pkg.sv
// rtl/uart_aes_pkg.sv - shared command codes, word size and sequencer state type
package uart_aes_pkg;

   localparam logic [7:0] CMD_WRITE      = 8'h01;
   localparam logic [7:0] CMD_READ       = 8'h02;
   localparam int         BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      BUS,
      TX
   } seq_state_t;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// rtl/uart_cmd_sequencer_if.sv - UART byte, register bus and status signals of the sequencer
interface uart_cmd_sequencer_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_req;
   logic        bus_we;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        busy;
   logic        err_cmd;
   logic        err_tmo;
   logic        err_ovr;

   modport master (
      input  rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
      output tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata,
             busy, err_cmd, err_tmo, err_ovr
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
      input  tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata,
             busy, err_cmd, err_tmo, err_ovr
   );

endinterface

// File: rtl/cmd_timeout_timer.sv
// rtl/cmd_timeout_timer.sv - saturating cycle counter that flags when MAX cycles have elapsed
module cmd_timeout_timer #(
   parameter int MAX = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int            W    = $clog2(MAX + 1);
   localparam logic [W-1:0]  TERM = W'(MAX);

   logic [W-1:0] cnt;

   // clr dominates en so a byte arriving in the expiry cycle restarts the window
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != TERM)
         cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == TERM);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - parses [cmd][addr][d0..d3] from UART, runs one bus access, returns read data
module uart_cmd_sequencer
   import uart_aes_pkg::*;
#(
   parameter int          BYTE_TIMEOUT = 1_200_000,
   parameter int          BUS_TIMEOUT  = 256,
   parameter logic [31:0] ERR_RDATA    = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_cmd_sequencer_if.master  io
);

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   seq_state_t  state, state_nxt;
   logic [1:0]  cnt;
   logic        we;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err_cmd_q, err_tmo_q, err_ovr_q;
   logic        byte_run, byte_tmo, bus_tmo, cmd_ok;

   assign byte_run = (state == ADDR) || (state == WDATA);
   assign cmd_ok   = (io.rx_data == CMD_WRITE) || (io.rx_data == CMD_READ);

   cmd_timeout_timer #(.MAX(BYTE_TIMEOUT)) u_byte_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (byte_run),
      .clr     (!byte_run || io.rx_valid),
      .expired (byte_tmo)
   );

   cmd_timeout_timer #(.MAX(BUS_TIMEOUT)) u_bus_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (state == BUS),
      .clr     (state != BUS),
      .expired (bus_tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.rx_valid && cmd_ok) state_nxt = ADDR;
         ADDR:    if (io.rx_valid)           state_nxt = we ? WDATA : BUS;
                  else if (byte_tmo)         state_nxt = IDLE;
         WDATA:   if (io.rx_valid) begin
                     if (cnt == LAST_BYTE)   state_nxt = BUS;
                  end else if (byte_tmo)     state_nxt = IDLE;
         // a late ack in the expiry cycle still completes normally
         BUS:     if (io.bus_ack || bus_tmo) state_nxt = we ? IDLE : TX;
         TX:      if (io.tx_ready && cnt == LAST_BYTE) state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         we        <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         rdata     <= '0;
         err_cmd_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         err_cmd_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovr_q <= 1'b0;
         case (state)
            IDLE: if (io.rx_valid) begin
               if (cmd_ok) begin
                  we    <= (io.rx_data == CMD_WRITE);
                  wdata <= '0;
               end else begin
                  err_cmd_q <= 1'b1;
               end
            end
            ADDR: if (io.rx_valid) begin
               addr <= io.rx_data;
               cnt  <= '0;
            end else if (byte_tmo) begin
               err_tmo_q <= 1'b1;
            end
            WDATA: if (io.rx_valid) begin
               wdata[{cnt, 3'b000} +: 8] <= io.rx_data;
               cnt                       <= cnt + 2'd1;
            end else if (byte_tmo) begin
               err_tmo_q <= 1'b1;
            end
            BUS: begin
               err_ovr_q <= io.rx_valid;
               if (io.bus_ack) begin
                  if (!we) rdata <= io.bus_rdata;
                  cnt <= '0;
               end else if (bus_tmo) begin
                  err_tmo_q <= 1'b1;
                  if (!we) rdata <= ERR_RDATA;
                  cnt <= '0;
               end
            end
            TX: begin
               err_ovr_q <= io.rx_valid;
               if (io.tx_ready) cnt <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      io.busy      = (state != IDLE);
      io.bus_req   = (state == BUS);
      io.bus_we    = we;
      io.bus_addr  = addr;
      io.bus_wdata = wdata;
      io.tx_valid  = (state == TX);
      io.tx_data   = (state == TX) ? rdata[{cnt, 3'b000} +: 8] : 8'h00;
      io.err_cmd   = err_cmd_q;
      io.err_tmo   = err_tmo_q;
      io.err_ovr   = err_ovr_q;
   end

endmodule
